// File: rtl/sdr_bridge_pkg.sv
// Shared types and helpers for the decoder-to-SDRAM-controller command bridge.
package sdr_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_RD = 3'd2,
    DONE    = 3'd3,
    REARM   = 3'd4
  } bridgeState_t;

  localparam logic [15:0] DEFAULT_ERR_DATA = 16'hDEAD;

  // Counter width able to hold the value `timeout` itself.
  function automatic int timerWidth(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sdr_bridge_timeout.sv
// Loadable up-counter that stops at LIMIT and flags it; count is 0 on the first enabled cycle after load.
// No backpressure: the FSM drives load/en every cycle and reads the expired flag combinationally.
module sdr_bridge_timeout
  import sdr_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = timerWidth(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/sdr_cmd_bridge.sv
// Turns a held RD/WR level from the command decoder into one ACK-handshaken controller transaction.
// Zero-wait latency: request seen in cycle 0, oMEM_REQ in cycle 1, oDONE in cycle 2; stalls are bounded by TIMEOUT.
module sdr_cmd_bridge
  import sdr_bridge_pkg::*;
#(
  parameter int                ADDR_W   = 22,
  parameter int                DATA_W   = 16,
  parameter int                TIMEOUT  = 1023,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEFAULT_ERR_DATA)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRD,
  input  logic              iWR,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic [DATA_W-1:0] iDATA,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDONE,
  output logic              oERR,
  input  logic              iERR_CLR,
  output logic              oMEM_REQ,
  output logic              oMEM_WE,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_WDATA,
  input  logic              iMEM_ACK,
  input  logic              iMEM_RVALID,
  input  logic [DATA_W-1:0] iMEM_RDATA
);

  bridgeState_t state;
  logic         timerExpired;
  logic         timeoutHit;

  sdr_bridge_timeout #(
    .TIMEOUT(TIMEOUT)
  ) uTimeout (
    .clk    (iCLK),
    .rst    (iRST),
    .load   (state == IDLE),
    .en     ((state == REQ) || (state == WAIT_RD)),
    .expired(timerExpired)
  );

  // A controller response in the terminal cycle beats the abort.
  always_comb begin
    timeoutHit = 1'b0;
    if (timerExpired) begin
      if (state == REQ)     timeoutHit = !iMEM_ACK;
      if (state == WAIT_RD) timeoutHit = !iMEM_RVALID;
    end
  end

  // The oMEM_* registers double as the latched request for the whole transaction.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      oDATA      <= '0;
      oDONE      <= 1'b0;
      oERR       <= 1'b0;
      oMEM_REQ   <= 1'b0;
      oMEM_WE    <= 1'b0;
      oMEM_ADDR  <= '0;
      oMEM_WDATA <= '0;
    end else begin
      oDONE <= 1'b0;

      if (timeoutHit) begin
        oERR <= 1'b1;
      end else if (iERR_CLR) begin
        oERR <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (iRD || iWR) begin
            oMEM_WE    <= iWR;
            oMEM_ADDR  <= iADDR;
            oMEM_WDATA <= iDATA;
            oMEM_REQ   <= 1'b1;
            state      <= REQ;
          end
        end

        REQ: begin
          if (iMEM_ACK) begin
            oMEM_REQ <= 1'b0;
            if (oMEM_WE || iMEM_RVALID) begin
              if (!oMEM_WE) oDATA <= iMEM_RDATA;
              oDONE <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT_RD;
            end
          end else if (timeoutHit) begin
            oMEM_REQ <= 1'b0;
            if (!oMEM_WE) oDATA <= ERR_DATA;
            oDONE <= 1'b1;
            state <= DONE;
          end
        end

        WAIT_RD: begin
          if (iMEM_RVALID) begin
            oDATA <= iMEM_RDATA;
            oDONE <= 1'b1;
            state <= DONE;
          end else if (timeoutHit) begin
            oDATA <= ERR_DATA;
            oDONE <= 1'b1;
            state <= DONE;
          end
        end

        DONE: state <= REARM;

        // A level still held from the finished command must drop before a new one is accepted.
        REARM: begin
          if (!iRD && !iWR) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_cmd_bridge.sv
// Randomized bench for sdr_cmd_bridge against a transaction-timeline model.
module tb_sdr_cmd_bridge;

  localparam int TO = 15;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iRD, iWR, iERR_CLR, iMEM_ACK, iMEM_RVALID;
  logic [21:0] iADDR;
  logic [15:0] iDATA, iMEM_RDATA;
  logic [15:0] oDATA, oMEM_WDATA;
  logic        oDONE, oERR, oMEM_REQ, oMEM_WE;
  logic [21:0] oMEM_ADDR;

  sdr_cmd_bridge #(.ADDR_W(22), .DATA_W(16), .TIMEOUT(TO), .ERR_DATA(16'hDEAD)) dut (
    .iCLK(iCLK), .iRST(iRST), .iRD(iRD), .iWR(iWR), .iADDR(iADDR), .iDATA(iDATA),
    .oDATA(oDATA), .oDONE(oDONE), .oERR(oERR), .iERR_CLR(iERR_CLR),
    .oMEM_REQ(oMEM_REQ), .oMEM_WE(oMEM_WE), .oMEM_ADDR(oMEM_ADDR), .oMEM_WDATA(oMEM_WDATA),
    .iMEM_ACK(iMEM_ACK), .iMEM_RVALID(iMEM_RVALID), .iMEM_RDATA(iMEM_RDATA)
  );

  always #5 iCLK = ~iCLK;

  // Expectations for the current cycle, written by the stimulus process.
  logic        checkEn = 1'b0;
  logic        eReq, eDone, eErr, eWe, eIface;
  logic [21:0] eAddr;
  logic [15:0] eWdata, eData;
  int          litKind = -1;
  logic [31:0] litExp;
  logic        cntClr = 1'b0;

  int checks = 0, errors = 0;
  int reqCnt = 0, doneCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge iCLK) begin
    if (checkEn) begin
      case (litKind)
        0: chk("reqCycles", reqCnt, litExp);
        1: chk("donePulses", doneCnt, litExp);
        2: chk("dataLit", {16'h0, oDATA}, litExp);
        3: chk("errLit", {31'h0, oERR}, litExp);
        default: ;
      endcase
      chk("memReq", oMEM_REQ, eReq);
      chk("done", oDONE, eDone);
      chk("rdData", oDATA, eData);
      chk("err", oERR, eErr);
      if (eReq || eIface) begin
        chk("memWe", oMEM_WE, eWe);
        chk("memAddr", oMEM_ADDR, eAddr);
        chk("memWdata", oMEM_WDATA, eWdata);
      end
    end
    if (cntClr) begin
      reqCnt = 0;
      doneCnt = 0;
    end
    if (oMEM_REQ === 1'b1) reqCnt++;
    if (oDONE === 1'b1) doneCnt++;
  end

  logic [15:0] prevData = 16'h0;
  logic        errState = 1'b0;

  task automatic step();
    @(posedge iCLK);
    #1;
    litKind = -1;
    cntClr = 1'b0;
  endtask

  task automatic idleExp();
    eReq = 0; eDone = 0; eData = prevData; eErr = errState; eIface = 0;
  endtask

  // Quiet cycle in IDLE: strays on the controller side, optional error clear and literal check.
  task automatic idleCycle(input bit clr, input int kind, input logic [31:0] exp, input bit clrCounters);
    iRD = 0; iWR = 0; iERR_CLR = clr;
    iMEM_ACK = 1'($urandom_range(0, 1));
    iMEM_RVALID = 1'($urandom_range(0, 1));
    iMEM_RDATA = 16'($urandom);
    idleExp();
    litKind = kind; litExp = exp; cntClr = clrCounters;
    step();
    if (clr) errState = 1'b0;
  endtask

  // One full command: t=0 is the IDLE cycle presenting the request; levels drop after `hold` cycles past DONE.
  task automatic runTxn(input bit rd, input bit wr, input logic [21:0] a, input logic [15:0] d,
                        input int ackLat, input int rvLat, input int hold, input int clrAt,
                        input logic [15:0] rdat);
    bit to;
    int A, R, reqEnd, doneCyc, last;
    logic [15:0] newData;
    bit ackOk, rvOk;
    to = 0;
    R = 0;
    A = 1 + ackLat;
    ackOk = (ackLat <= TO);
    if (!ackOk) begin
      to = 1; reqEnd = TO + 1; doneCyc = TO + 2;
    end else begin
      reqEnd = A;
      if (wr) doneCyc = A + 1;
      else begin
        R = A + rvLat;
        if (R - 1 <= TO) doneCyc = R + 1;
        else begin to = 1; doneCyc = TO + 2; end
      end
    end
    rvOk = !wr && ackOk && (R - 1 <= TO);
    newData = wr ? prevData : (to ? 16'hDEAD : rdat);
    last = doneCyc + hold + 1;
    for (int t = 0; t <= last; t++) begin
      bit lvl;
      lvl = (t <= doneCyc + hold);
      iRD = lvl & rd;
      iWR = lvl & wr;
      if (t == 0) begin iADDR = a; iDATA = d; end
      else begin iADDR = 22'($urandom); iDATA = 16'($urandom); end
      iMEM_ACK = ackOk && (t == A);
      iMEM_RVALID = rvOk && (t == R);
      iMEM_RDATA = (rvOk && t == R) ? rdat : 16'($urandom);
      if (t == 0 || t >= doneCyc) begin
        iMEM_ACK = iMEM_ACK | 1'($urandom_range(0, 1));
        iMEM_RVALID = iMEM_RVALID | 1'($urandom_range(0, 1));
      end
      if (!wr && ackOk && t > A && t < doneCyc)
        iMEM_ACK = 1'($urandom_range(0, 1));
      iERR_CLR = (t == clrAt);
      eReq = (t >= 1) && (t <= reqEnd);
      eDone = (t == doneCyc);
      eData = (t >= doneCyc) ? newData : prevData;
      eErr = errState;
      eIface = 0;
      eWe = wr; eAddr = a; eWdata = d;
      step();
      if (to && t == doneCyc - 1) errState = 1'b1;
      else if (t == clrAt) errState = 1'b0;
    end
    prevData = newData;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    iRST = 1; iRD = 0; iWR = 0; iERR_CLR = 0; iMEM_ACK = 0; iMEM_RVALID = 0;
    iADDR = '0; iDATA = '0; iMEM_RDATA = '0;
    eWe = 0; eAddr = '0; eWdata = '0; eIface = 1;
    eReq = 0; eDone = 0; eData = 0; eErr = 0;
    checkEn = 1;
    #1;
    step();
    step();
    iRST = 0;
    idleCycle(0, -1, 0, 1);

    // Write, level held afterwards: one transaction only.
    runTxn(0, 1, 22'h00123, 16'hA5A5, 0, 0, 3, -1, 16'h0);
    idleCycle(0, 0, 1, 0);
    idleCycle(0, 1, 1, 1);

    // Read with three cycles of controller read latency.
    runTxn(1, 0, 22'h00456, 16'h0, 0, 3, 0, -1, 16'h1234);
    idleCycle(0, 0, 1, 0);
    idleCycle(0, 2, 32'h1234, 1);

    // Stalled read: abort after the timer reaches TO.
    runTxn(1, 0, 22'h00789, 16'h0, 100, 0, 1, -1, 16'h5555);
    idleCycle(0, 0, TO + 1, 0);
    idleCycle(0, 2, 32'hDEAD, 0);
    idleCycle(0, 3, 1, 0);
    idleCycle(1, -1, 0, 0);
    idleCycle(0, 3, 0, 0);

    // Stalled write with a clear in the terminal cycle: set wins, data untouched.
    runTxn(0, 1, 22'h3FFFFF, 16'hFFFF, 100, 0, 0, TO + 1, 16'h0);
    idleCycle(0, 3, 1, 0);
    idleCycle(0, 2, 32'hDEAD, 0);
    idleCycle(1, -1, 0, 0);

    // Both levels high is a write; same-cycle ACK+RVALID on a read.
    runTxn(1, 1, 22'h00ABC, 16'h0F0F, 1, 0, 0, -1, 16'h0);
    runTxn(1, 0, 22'h00DEF, 16'h0, 2, 0, 0, -1, 16'h7E57);
    idleCycle(0, 2, 32'h7E57, 0);

    // Terminal-cycle responses beat the timeout.
    runTxn(0, 1, 22'h11111, 16'h2222, TO, 0, 0, -1, 16'h0);
    runTxn(1, 0, 22'h12345, 16'h0, 0, TO, 0, -1, 16'hBEEF);
    runTxn(1, 0, 22'h12346, 16'h0, 0, TO + 1, 0, 2, 16'hCAFE);
    idleCycle(1, -1, 0, 0);

    // Back-to-back reads with a single cycle of deassertion between.
    idleCycle(0, -1, 0, 1);
    runTxn(1, 0, 22'h00010, 16'h0, 0, 0, 0, -1, 16'h0101);
    runTxn(1, 0, 22'h00011, 16'h0, 0, 0, 0, -1, 16'h0202);
    idleCycle(0, 1, 2, 0);
    idleCycle(0, 0, 2, 0);

    // Reset while waiting for read data.
    iRD = 1; iWR = 0; iADDR = 22'h2AAAA; iDATA = 16'h0; iMEM_ACK = 0; iMEM_RVALID = 0;
    idleExp();
    step();
    iMEM_ACK = 1;
    eReq = 1; eWe = 0; eAddr = 22'h2AAAA; eWdata = 16'h0;
    step();
    iMEM_ACK = 0;
    eReq = 0;
    #1;
    iRST = 1;
    prevData = 16'h0; errState = 1'b0;
    eReq = 0; eDone = 0; eData = 0; eErr = 0; eIface = 1; eWe = 0; eAddr = '0; eWdata = '0;
    step();
    iRD = 0;
    step();
    iRST = 0;
    eIface = 0;
    cntClr = 1;
    for (int i = 0; i < 3; i++) begin
      iMEM_RVALID = 1; iMEM_ACK = 1; iMEM_RDATA = 16'h9999;
      idleExp();
      step();
    end
    idleCycle(0, 1, 0, 0);
    runTxn(1, 0, 22'h00042, 16'h0, 1, 1, 0, -1, 16'h4242);
    idleCycle(0, 2, 32'h4242, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int k, ackLat, rvLat, hold, clrAt;
      k = $urandom_range(0, 2);
      ackLat = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
      rvLat = ($urandom_range(0, 7) == 0) ? TO - 1 + $urandom_range(0, 3) : $urandom_range(0, 4);
      hold = $urandom_range(0, 3);
      clrAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 25) : -1;
      runTxn(k != 1, k != 0, 22'($urandom), 16'($urandom), ackLat, rvLat, hold, clrAt, 16'($urandom));
      if ($urandom_range(0, 2) == 0) idleCycle(1'($urandom_range(0, 1)), -1, 0, 0);
    end

    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
